// File: rtl/bcd_to_seven_seg_pkg.sv
// Segment pattern and bit-index constants shared by the seven-segment decoder blocks.
// Patterns are active-high, ordered {g,f,e,d,c,b,a} with bit0 = a.
package seven_seg_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ALL   = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h01 << SEG_G_BIT;

  // Convert an active-high pattern to pin polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/bcd_to_seven_seg_if.sv
// Digit-side signal bundle for one seven-segment digit decoder.
// master drives the digit code and controls; slave is the decoder.
interface bcd_to_seven_seg_if;
  logic [3:0] bcd_in;
  logic       en;
  logic       lamp_test;
  logic       blank;
  logic       rbi;
  logic [6:0] seg_out;
  logic       rbo;
  logic       err;

  modport master (
    output bcd_in, en, lamp_test, blank, rbi,
    input  seg_out, rbo, err
  );

  modport slave (
    input  bcd_in, en, lamp_test, blank, rbi,
    output seg_out, rbo, err
  );
endinterface

// File: rtl/bcd_to_seven_seg_lut.sv
// Combinational code-to-pattern lookup, reusable by multi-digit wrappers.
// With BCD_TO_SEVEN_SEG_HEX_EN defined, codes 10-15 show hex letters and never flag invalid.
module seven_seg_lut
  import seven_seg_pkg::*;
#(
  parameter logic [6:0] INVALID_PATTERN = SEG_DASH
) (
  input  logic [3:0] code,
  output logic [6:0] pattern,
  output logic       invalid
);

  always_comb begin
    pattern = INVALID_PATTERN;
    invalid = 1'b0;
    unique case (code)
      4'd0:  pattern = SEG_0;
      4'd1:  pattern = SEG_1;
      4'd2:  pattern = SEG_2;
      4'd3:  pattern = SEG_3;
      4'd4:  pattern = SEG_4;
      4'd5:  pattern = SEG_5;
      4'd6:  pattern = SEG_6;
      4'd7:  pattern = SEG_7;
      4'd8:  pattern = SEG_8;
      4'd9:  pattern = SEG_9;
`ifdef BCD_TO_SEVEN_SEG_HEX_EN
      4'd10: pattern = SEG_A;
      4'd11: pattern = SEG_B;
      4'd12: pattern = SEG_C;
      4'd13: pattern = SEG_D;
      4'd14: pattern = SEG_E;
      4'd15: pattern = SEG_F;
`else
      default: begin
        pattern = INVALID_PATTERN;
        invalid = 1'b1;
      end
`endif
    endcase
  end

endmodule

// File: rtl/bcd_to_seven_seg.sv
// Single-digit BCD to seven-segment driver: override mux, polarity, registered outputs.
// Optional hex letters for codes 10-15 via BCD_TO_SEVEN_SEG_HEX_EN (see seven_seg_lut).
module bcd_to_seven_seg
  import seven_seg_pkg::*;
#(
  parameter bit         ACTIVE_LOW      = 1'b0,
  parameter logic [6:0] INVALID_PATTERN = SEG_DASH
) (
  input  logic                clk,
  input  logic                rst,
  bcd_to_seven_seg_if.slave   bus
);

  logic [6:0] lut_pattern;
  logic       lut_invalid;
  logic [6:0] pattern_sel;
  logic       rbo_next;

  seven_seg_lut #(
    .INVALID_PATTERN (INVALID_PATTERN)
  ) u_lut (
    .code    (bus.bcd_in),
    .pattern (lut_pattern),
    .invalid (lut_invalid)
  );

  // Lamp test beats blank; ripple blanking only suppresses a literal zero.
  always_comb begin
    pattern_sel = lut_pattern;
    rbo_next    = 1'b0;
    if (bus.lamp_test) begin
      pattern_sel = SEG_ALL;
    end else if (bus.blank) begin
      pattern_sel = SEG_BLANK;
    end else if (bus.rbi && (bus.bcd_in == 4'd0)) begin
      pattern_sel = SEG_BLANK;
      rbo_next    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.seg_out <= seg_polarity(SEG_BLANK, ACTIVE_LOW);
      bus.rbo     <= 1'b0;
      bus.err     <= 1'b0;
    end else if (bus.en) begin
      bus.seg_out <= seg_polarity(pattern_sel, ACTIVE_LOW);
      bus.rbo     <= rbo_next;
      bus.err     <= lut_invalid;
    end
  end

endmodule

// File: tb/tb_bcd_to_seven_seg.sv
// Bench for bcd_to_seven_seg: active-high and active-low instances driven in lockstep
// and checked against a table-driven reference of the digit decoder.
module tb_bcd_to_seven_seg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_to_seven_seg_if if0 ();
  bcd_to_seven_seg_if if1 ();

  assign if1.bcd_in    = if0.bcd_in;
  assign if1.en        = if0.en;
  assign if1.lamp_test = if0.lamp_test;
  assign if1.blank     = if0.blank;
  assign if1.rbi       = if0.rbi;

  bcd_to_seven_seg #(.ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bcd_to_seven_seg #(.ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [6:0] font [16];
  logic [6:0] exp_seg;
  logic       exp_rbo;
  logic       exp_err;
  int n_cmp = 0;
  int n_err = 0;
`ifdef BCD_TO_SEVEN_SEG_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  initial begin
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    if (HEX) begin
      font[10] = 7'h77; font[11] = 7'h7C; font[12] = 7'h39;
      font[13] = 7'h5E; font[14] = 7'h79; font[15] = 7'h71;
    end
  end

  task automatic drive(input logic [3:0] bcd, input logic en, input logic lt,
                       input logic bl, input logic rbi);
    if0.bcd_in = bcd; if0.en = en; if0.lamp_test = lt; if0.blank = bl; if0.rbi = rbi;
  endtask

  // Advance one edge, updating the reference from the inputs present at that edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      exp_seg = 7'h00; exp_rbo = 1'b0; exp_err = 1'b0;
    end else if (if0.en) begin
      exp_err = (if0.bcd_in > 4'd9) && !HEX;
      exp_rbo = 1'b0;
      if (if0.lamp_test)                           exp_seg = 7'h7F;
      else if (if0.blank)                          exp_seg = 7'h00;
      else if (if0.rbi && if0.bcd_in == 4'd0) begin exp_seg = 7'h00; exp_rbo = 1'b1; end
      else                                         exp_seg = font[if0.bcd_in];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    n_cmp++;
    if ({if0.seg_out, if1.seg_out, if0.rbo, if0.err, if1.rbo, if1.err} !== {7'h00, 7'h7F, 4'b0000}) begin
      n_err++;
      $display("FAIL reset: seg=%h/%h rbo=%b err=%b, expected seg=00/7f rbo=0 err=0",
               if0.seg_out, if1.seg_out, if0.rbo, if0.err);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep(input int lo, input int hi, input string name);
    for (int d = lo; d <= hi; d++) begin
      drive(d[3:0], 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      n_cmp++;
      if ({if0.seg_out, if1.seg_out, if0.rbo, if0.err, if1.rbo, if1.err} !==
          {exp_seg, ~exp_seg, exp_rbo, exp_err, exp_rbo, exp_err}) begin
        n_err++;
        $display("FAIL %s code %0d: seg=%h/%h rbo=%b err=%b, expected seg=%h/%h rbo=%b err=%b",
                 name, d, if0.seg_out, if1.seg_out, if0.rbo, if0.err,
                 exp_seg, ~exp_seg, exp_rbo, exp_err);
      end
    end
  endtask

  task automatic test_overrides();
    logic [3:0] want [3];
    want = '{4'd0, 4'd0, 4'd0};
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive(4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        1: drive(4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        default: drive(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      endcase
      cycle();
      n_cmp++;
      if ({if0.seg_out, if1.seg_out, if0.rbo, if0.err} !== {exp_seg, ~exp_seg, exp_rbo, exp_err}) begin
        n_err++;
        $display("FAIL override step %0d: seg=%h/%h rbo=%b err=%b, expected seg=%h rbo=%b err=%b",
                 s, if0.seg_out, if1.seg_out, if0.rbo, if0.err, exp_seg, exp_rbo, exp_err);
      end
      want[s] = 4'd0;
    end
  endtask

  task automatic test_ripple();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: drive(4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        1: drive(4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        default: drive(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      endcase
      cycle();
      n_cmp++;
      if ({if0.seg_out, if1.seg_out, if0.rbo, if1.rbo, if0.err} !== {exp_seg, ~exp_seg, exp_rbo, exp_rbo, exp_err}) begin
        n_err++;
        $display("FAIL ripple step %0d: seg=%h/%h rbo=%b err=%b, expected seg=%h rbo=%b err=%b",
                 s, if0.seg_out, if1.seg_out, if0.rbo, if0.err, exp_seg, exp_rbo, exp_err);
      end
    end
  endtask

  task automatic test_hold();
    drive(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if ({if0.seg_out, if1.seg_out} !== {7'h07, 7'h78}) begin
        n_err++;
        $display("FAIL hold cycle %0d: seg=%h/%h, expected seg=07/78", i, if0.seg_out, if1.seg_out);
      end
    end
    drive(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    n_cmp++;
    if ({if0.seg_out, if1.seg_out, if0.err} !== {7'h5B, 7'h24, 1'b0}) begin
      n_err++;
      $display("FAIL hold release: seg=%h/%h err=%b, expected seg=5b/24 err=0",
               if0.seg_out, if1.seg_out, if0.err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), 1'($urandom));
      if ($urandom_range(0, 2) == 0) if0.bcd_in = 4'd0;
      cycle();
      n_cmp++;
      if ({if0.seg_out, if1.seg_out, if0.rbo, if0.err, if1.rbo, if1.err} !==
          {exp_seg, ~exp_seg, exp_rbo, exp_err, exp_rbo, exp_err}) begin
        n_err++;
        $display("FAIL random iter %0d: seg=%h/%h rbo=%b err=%b, expected seg=%h/%h rbo=%b err=%b",
                 i, if0.seg_out, if1.seg_out, if0.rbo, if0.err,
                 exp_seg, ~exp_seg, exp_rbo, exp_err);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    exp_seg = 7'h00; exp_rbo = 1'b0; exp_err = 1'b0;
    drive(4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_sweep(0, 9, "sweep");
    test_sweep(10, 15, "invalid");
    test_overrides();
    test_ripple();
    test_hold();
    test_random();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
